// File: rtl/dht_multi_apb.sv
// rtl/dht_multi_apb.sv - APB3 controller for up to four single-wire DHT11/DHT22 humidity/temperature sensors
module dht_multi_apb #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int NUM_CH     = 1,
  parameter int START_US   = 18000,
  parameter int REL_US     = 30,
  parameter int BIT1_TH_US = 40,
  parameter int TIMEOUT_US = 200
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [4:0]        PADDR,
  input  logic [31:0]       PWDATA,
  input  logic              PWRITE,
  input  logic              PENABLE,
  input  logic              PSEL,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  inout  wire  [NUM_CH-1:0] dht_io,
  output logic              irq
);

  localparam int TDIV = (CLK_HZ / 1_000_000 > 1) ? CLK_HZ / 1_000_000 : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HOST_LOW, S_HOST_REL, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_CHECK
  } state_t;

  state_t state;

  logic [31:0] tdiv_cnt;
  logic        tick;
  logic [NUM_CH-1:0] sync1, sync2;
  logic [3:0]  in4;
  logic        sel_in;

  logic        auto_en, irq_en;
  logic [1:0]  ch_sel, ch;
  logic [15:0] period;
  logic        valid, cksum_err, timeout_err, done;
  logic [31:0] data_reg;
  logic [15:0] sum_reg;

  logic [31:0] us_cnt;
  logic [5:0]  bit_cnt;
  logic [39:0] shreg;
  logic        drive_low;
  logic [7:0]  calc_sum;

  logic [9:0]  ms_us;
  logic [15:0] ms_cnt;
  logic [15:0] period_eff;
  logic        auto_trig;

  logic        acc, wr, wr_ctrl, wr_status, wr_period;
  logic [1:0]  start_ch_src;
  logic        busy, start_req, to_hit;
  logic        unused_bits;

  assign unused_bits = ^{PADDR[1:0], PWDATA[31:16]};

  // APB decode: zero-wait-state, writes commit at the edge ending the access phase
  assign acc       = PSEL & PENABLE;
  assign PREADY    = acc;
  assign wr        = acc & PWRITE;
  assign wr_ctrl   = wr && (PADDR[4:2] == 3'd0);
  assign wr_status = wr && (PADDR[4:2] == 3'd1);
  assign wr_period = wr && (PADDR[4:2] == 3'd4);

  assign busy         = (state != S_IDLE);
  assign start_ch_src = wr_ctrl ? PWDATA[5:4] : ch_sel;
  assign start_req    = !busy && ((wr_ctrl && PWDATA[0]) || auto_trig);
  assign period_eff   = (period == 16'd0) ? 16'd1 : period;
  assign auto_trig    = auto_en && !busy && (ms_cnt >= period_eff);
  assign to_hit       = tick && (us_cnt == 32'(TIMEOUT_US - 1));
  assign calc_sum     = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];
  assign irq          = irq_en & done;

  // Lines are only ever pulled low, and only the latched channel during the host start pulse
  for (genvar i = 0; i < NUM_CH; i++) begin : g_line
    assign dht_io[i] = (drive_low && ch == 2'(i)) ? 1'b0 : 1'bz;
  end

  // Pad the synchronised inputs to four lanes so the channel index is always in range
  always_comb begin
    in4 = 4'hF;
    in4[NUM_CH-1:0] = sync2;
  end
  assign sel_in = in4[ch];

  // Register read mux, only drives data during the access phase
  always_comb begin
    PRDATA = 32'd0;
    if (acc) begin
      case (PADDR[4:2])
        3'd0:    PRDATA = {26'd0, ch_sel, 1'b0, irq_en, auto_en, 1'b0};
        3'd1:    PRDATA = {27'd0, done, timeout_err, cksum_err, valid, busy};
        3'd2:    PRDATA = data_reg;
        3'd3:    PRDATA = {16'd0, sum_reg};
        3'd4:    PRDATA = {16'd0, period};
        default: PRDATA = 32'd0;
      endcase
    end
  end

  // Free-running 1 us tick divider
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) tdiv_cnt <= 32'd0;
    else if (tick) tdiv_cnt <= 32'd0;
    else tdiv_cnt <= tdiv_cnt + 32'd1;
  end
  assign tick = (tdiv_cnt == 32'(TDIV - 1));

  // Two-flop synchroniser on every sensor line (idle level is high)
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= dht_io;
      sync2 <= sync1;
    end
  end

  // Auto-sample interval: counts idle milliseconds, held at zero while busy or AUTO is off
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ms_us  <= 10'd0;
      ms_cnt <= 16'd0;
    end else if (!auto_en || busy) begin
      ms_us  <= 10'd0;
      ms_cnt <= 16'd0;
    end else if (tick) begin
      if (ms_us == 10'd999) begin
        ms_us  <= 10'd0;
        ms_cnt <= ms_cnt + 16'd1;
      end else begin
        ms_us <= ms_us + 10'd1;
      end
    end
  end

  // Register file and protocol engine; a DONE set is placed after the W1C so it wins
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= S_IDLE;
      auto_en     <= 1'b0;
      irq_en      <= 1'b0;
      ch_sel      <= 2'd0;
      ch          <= 2'd0;
      period      <= 16'd0;
      valid       <= 1'b0;
      cksum_err   <= 1'b0;
      timeout_err <= 1'b0;
      done        <= 1'b0;
      data_reg    <= 32'd0;
      sum_reg     <= 16'd0;
      us_cnt      <= 32'd0;
      bit_cnt     <= 6'd0;
      shreg       <= 40'd0;
      drive_low   <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        auto_en <= PWDATA[1];
        irq_en  <= PWDATA[2];
        ch_sel  <= PWDATA[5:4];
      end
      if (wr_period) period <= PWDATA[15:0];
      if (wr_status && PWDATA[4]) done <= 1'b0;

      case (state)
        S_IDLE: begin
          drive_low <= 1'b0;
          if (start_req) begin
            ch          <= (32'(start_ch_src) < 32'(NUM_CH)) ? start_ch_src : 2'd0;
            valid       <= 1'b0;
            cksum_err   <= 1'b0;
            timeout_err <= 1'b0;
            us_cnt      <= 32'd0;
            bit_cnt     <= 6'd0;
            drive_low   <= 1'b1;
            state       <= S_HOST_LOW;
          end
        end
        S_HOST_LOW: if (tick) begin
          if (us_cnt == 32'(START_US - 1)) begin
            us_cnt    <= 32'd0;
            drive_low <= 1'b0;
            state     <= S_HOST_REL;
          end else us_cnt <= us_cnt + 32'd1;
        end
        S_HOST_REL: if (tick) begin
          if (us_cnt == 32'(REL_US - 1)) begin
            us_cnt <= 32'd0;
            state  <= S_RESP_LOW;
          end else us_cnt <= us_cnt + 32'd1;
        end
        S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH: begin
          if ((state == S_RESP_LOW && sel_in) || (state == S_RESP_HIGH && !sel_in) ||
              (state == S_BIT_LOW && sel_in)) begin
            us_cnt <= 32'd0;
            state  <= (state == S_RESP_LOW) ? S_RESP_HIGH : (state == S_RESP_HIGH) ? S_BIT_LOW : S_BIT_HIGH;
          end else if (state == S_BIT_HIGH && !sel_in) begin
            shreg   <= {shreg[38:0], (us_cnt > 32'(BIT1_TH_US))};
            bit_cnt <= bit_cnt + 6'd1;
            us_cnt  <= 32'd0;
            state   <= (bit_cnt == 6'd39) ? S_CHECK : S_BIT_LOW;
          end else if (to_hit) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
            state       <= S_IDLE;
          end else if (tick) begin
            us_cnt <= us_cnt + 32'd1;
          end
        end
        S_CHECK: begin
          sum_reg <= {calc_sum, shreg[7:0]};
          if (calc_sum == shreg[7:0]) begin
            data_reg <= shreg[39:8];
            valid    <= 1'b1;
          end else begin
            cksum_err <= 1'b1;
          end
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dht_multi_apb.sv
// tb/tb_dht_multi_apb.sv - scoreboard bench for dht_multi_apb with a behavioural DHT sensor model
module tb_dht_multi_apb;

  localparam int NCH = 4;
  localparam logic [4:0] A_CTRL = 5'h00, A_STATUS = 5'h04, A_DATA = 5'h08, A_SUM = 5'h0C, A_PERIOD = 5'h10;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic [4:0]  PADDR = 5'd0;
  logic [31:0] PWDATA = 32'd0;
  logic        PWRITE = 1'b0, PENABLE = 1'b0, PSEL = 1'b0;
  logic [31:0] PRDATA;
  logic        PREADY;
  wire  [NCH-1:0] dht_io;
  logic        irq;
  logic [NCH-1:0] sdrv = '0;

  for (genvar i = 0; i < NCH; i++) begin : g_line
    pullup (dht_io[i]);
    assign dht_io[i] = sdrv[i] ? 1'b0 : 1'bz;
  end

  dht_multi_apb #(
    .CLK_HZ(2_000_000), .NUM_CH(NCH), .START_US(100), .REL_US(30),
    .BIT1_TH_US(40), .TIMEOUT_US(200)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PENABLE(PENABLE), .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY), .dht_io(dht_io), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // cycle counter and event monitors sampled on the falling edge
  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  logic irq_q = 1'b0, l0_q = 1'b1;
  int irq_rises = 0, t_irq = 0, falls = 0, t_fall = 0;
  always @(negedge PCLK) begin
    if (irq && !irq_q) begin irq_rises <= irq_rises + 1; t_irq <= cyc; end
    if (l0_q && !dht_io[0] && !sdrv[0]) begin falls <= falls + 1; t_fall <= cyc; end
    irq_q <= irq;
    l0_q  <= dht_io[0];
  end

  task automatic wait_us(input int n);
    repeat (2 * n) @(negedge PCLK);
  endtask

  // sensor model: answers a host low pulse of >= 50 us on sensor_ch
  logic [1:0]  sensor_ch = 2'd0;
  logic [39:0] sensor_bytes = 40'd0;
  bit sensor_on = 1'b0, sensor_busy = 1'b0, in_bit_high = 1'b0;

  initial begin : sensor
    int lowcnt;
    int c;
    lowcnt = 0;
    forever begin
      @(negedge PCLK);
      c = int'(sensor_ch);
      if (!dht_io[c] && !sdrv[c]) lowcnt++;
      else begin
        if (lowcnt >= 100 && sensor_on) begin
          sensor_busy = 1'b1;
          wait_us(20); sdrv[c] = 1'b1; wait_us(80); sdrv[c] = 1'b0; wait_us(80);
          for (int b = 39; b >= 0; b--) begin
            sdrv[c] = 1'b1; wait_us(30); sdrv[c] = 1'b0;
            in_bit_high = 1'b1; wait_us(sensor_bytes[b] ? 70 : 26); in_bit_high = 1'b0;
          end
          sdrv[c] = 1'b1; wait_us(30); sdrv[c] = 1'b0;
          sensor_busy = 1'b0;
        end
        lowcnt = 0;
      end
    end
  end

  task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
    @(posedge PCLK); #1 PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] a, output logic [31:0] d);
    @(posedge PCLK); #1 PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge PCLK); #1 PENABLE = 1'b1; #1 d = PRDATA;
    @(posedge PCLK); #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_sensor_idle();
    int k;
    k = 0;
    while (sensor_busy && k < 10000) begin @(negedge PCLK); k++; end
  endtask

  typedef struct { logic [31:0] status; logic [31:0] data; logic [31:0] sum; } exp_t;
  exp_t exp_q[$];
  logic [31:0] model_data = 32'd0;

  // push the expected outcome, run one frame, then pop and compare on completion
  task automatic run_frame(input logic [31:0] ctrl, input logic [39:0] bytes, input bit mid);
    exp_t e, g;
    logic [7:0] calc;
    logic [3:0] lines;
    logic [31:0] st;
    int k, r0;
    sensor_on = 1'b1; sensor_ch = ctrl[5:4]; sensor_bytes = bytes;
    wait_sensor_idle();
    apb_write(A_STATUS, 32'h10);
    calc = bytes[39:32] + bytes[31:24] + bytes[23:16] + bytes[15:8];
    if (calc == bytes[7:0]) model_data = bytes[39:8];
    e.status = (calc == bytes[7:0]) ? 32'h12 : 32'h14;
    e.data = model_data;
    e.sum = {16'd0, calc, bytes[7:0]};
    exp_q.push_back(e);
    r0 = irq_rises;
    apb_write(A_CTRL, ctrl);
    wait_us(20);
    lines = 4'hF;
    lines[ctrl[5:4]] = 1'b0;
    chk("line_sel", 32'(dht_io), 32'(lines));
    if (mid) begin
      wait_us(1000);
      apb_write(A_CTRL, ctrl);
    end
    st = 32'd0; k = 0;
    while (!st[4] && k < 6000) begin apb_read(A_STATUS, st); k++; end
    if (!st[4]) chk("wait_done", st, 32'h10);
    apb_read(A_DATA, g.data);
    apb_read(A_SUM, g.sum);
    g.status = st;
    e = exp_q.pop_front();
    chk("status", g.status, e.status);
    chk("data", g.data, e.data);
    chk("sum", g.sum, e.sum);
    if (mid) begin
      wait_us(300);
      chk("one_done", 32'(irq_rises - r0), 32'd1);
    end
  endtask

  initial begin : watchdog
    #(20_000_000);
    $display("FAIL watchdog expired");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] d;
    int k, r0, f0, td, dt;
    repeat (5) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    @(posedge PCLK); #1;

    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_line", 32'(dht_io), 32'hF);
    for (int a = 0; a < 5; a++) begin
      apb_read(5'(a * 4), d);
      chk($sformatf("rst_reg%0d", a), d, 32'd0);
    end
    apb_write(5'h1C, 32'hFFFF_FFFF);
    apb_read(5'h1C, d);
    chk("unmapped", d, 32'd0);
    apb_write(A_PERIOD, 32'h1234_ABCD);
    apb_read(A_PERIOD, d);
    chk("period_rw", d, 32'h0000_ABCD);
    apb_write(A_CTRL, 32'h34);
    apb_read(A_CTRL, d);
    chk("ctrl_rw", d, 32'h34);
    apb_write(A_CTRL, 32'h0);

    run_frame(32'h1, 40'h35_00_18_05_52, 1'b0);
    run_frame(32'h1, 40'h35_00_18_05_53, 1'b0);

    // silent sensor: timeout after START_US + REL_US + TIMEOUT_US = 330 us = 660 cycles
    sensor_on = 1'b0; sensor_ch = 2'd0;
    apb_write(A_STATUS, 32'h10);
    r0 = irq_rises;
    apb_write(A_CTRL, 32'h5);
    td = cyc;
    k = 0;
    while (irq_rises == r0 && k < 2000) begin @(negedge PCLK); k++; end
    chk("to_irq", 32'(irq), 32'd1);
    dt = t_irq - td;
    chk("to_time", (dt >= 654 && dt <= 666) ? 32'd660 : 32'(dt), 32'd660);
    apb_read(A_STATUS, d);
    chk("to_status", d, 32'h18);
    apb_read(A_DATA, d);
    chk("to_data", d, model_data);
    chk("to_line", 32'(dht_io), 32'hF);
    apb_write(A_STATUS, 32'h10);
    chk("irq_w1c", 32'(irq), 32'd0);

    run_frame(32'h25, 40'h12_34_56_78_14, 1'b1);

    // auto mode with a silent sensor: next start 2 ms (4000 cycles) after each completion
    sensor_on = 1'b0; sensor_ch = 2'd0;
    apb_write(A_STATUS, 32'h10);
    apb_write(A_PERIOD, 32'd2);
    apb_write(A_CTRL, 32'h6);
    for (int n = 0; n < 2; n++) begin
      r0 = irq_rises; k = 0;
      while (irq_rises == r0 && k < 8000) begin @(negedge PCLK); k++; end
      td = t_irq; f0 = falls;
      apb_write(A_STATUS, 32'h10);
      k = 0;
      while (falls == f0 && k < 6000) begin @(negedge PCLK); k++; end
      dt = t_fall - td;
      chk("auto_gap", (dt >= 3996 && dt <= 4006) ? 32'd4000 : 32'(dt), 32'd4000);
    end
    r0 = irq_rises; k = 0;
    while (irq_rises == r0 && k < 8000) begin @(negedge PCLK); k++; end
    apb_write(A_CTRL, 32'h4);
    apb_write(A_STATUS, 32'h10);
    f0 = falls;
    wait_us(3000);
    chk("auto_off", 32'(falls - f0), 32'd0);

    // reset during BIT_HIGH
    sensor_on = 1'b1; sensor_ch = 2'd0; sensor_bytes = 40'h35_00_18_05_52;
    apb_write(A_CTRL, 32'h5);
    k = 0;
    while (!in_bit_high && k < 8000) begin @(negedge PCLK); k++; end
    wait_us(5);
    @(posedge PCLK); #3 PRESETn = 1'b0;
    #1 chk("rst_bh_line", 32'(dht_io), 32'hF);
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;
    model_data = 32'd0;
    chk("rst_bh_irq", 32'(irq), 32'd0);
    for (int a = 0; a < 5; a++) begin
      apb_read(5'(a * 4), d);
      chk($sformatf("rst_bh_reg%0d", a), d, 32'd0);
    end

    // reset during the host start pulse releases the line at once
    wait_sensor_idle();
    apb_write(A_CTRL, 32'h1);
    wait_us(20);
    chk("host_low", 32'(dht_io[0]), 32'd0);
    @(posedge PCLK); #3 PRESETn = 1'b0;
    #1 chk("rst_hl_line", 32'(dht_io[0]), 32'd1);
    repeat (3) @(posedge PCLK);
    #1 PRESETn = 1'b1;

    run_frame(32'h1, 40'h40_0A_FF_01_4A, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dht_multi_apb.md
# dht_multi_apb

APB3 slave that controls up to four single-wire DHT11/DHT22-class humidity/temperature sensors through one shared protocol engine. Compared with the single-sensor controller, it adds a clock-rate parameter, a channel select, checksum validation, per-edge timeout detection, periodic auto-sampling and an interrupt. APB accesses are zero-wait-state: bus transfers never stall on a sensor transaction, and software polls STATUS or waits for `irq`. The block sits on the peripheral APB bus next to the other RISC-V SoC peripherals.

## Interface
- CLK_HZ, 100_000_000, PCLK frequency; 1 µs tick period = CLK_HZ/1_000_000 cycles
- NUM_CH, 1, number of sensor lines (1..4)
- START_US, 18000, host start-low duration
- REL_US, 30, host release-high duration before sampling
- BIT1_TH_US, 40, data-high time strictly greater than this decodes as 1
- TIMEOUT_US, 200, maximum wait for any expected sensor edge
- PCLK  in  1  clock
- PRESETn  in  1  asynchronous active-low reset
- PADDR  in  5  byte address; bits [4:2] select the register
- PWDATA  in  32  write data
- PWRITE, PENABLE, PSEL  in  1 each  APB control
- PRDATA  out  32  read data
- PREADY  out  1  transfer complete
- dht_io  inout  NUM_CH  open-drain sensor lines with external pull-ups
- irq  out  1  level interrupt

## Operation
- Registers:
  - 0x00 CTRL, RW: [0] START, write 1 = request, reads 0; [1] AUTO; [2] IRQ_EN; [5:4] CH_SEL.
  - 0x04 STATUS: [0] BUSY (RO); [1] VALID (RO); [2] CKSUM_ERR (RO); [3] TIMEOUT_ERR (RO); [4] DONE (W1C).
  - 0x08 DATA, RO: {hum_int, hum_dec, tmp_int, tmp_dec}.
  - 0x0C SUM, RO: [7:0] received checksum, [15:8] computed checksum.
  - 0x10 PERIOD, RW [15:0]: auto interval in ms; the value 0 behaves as 1.
  - Other addresses read 0; writes to them are ignored.
- Sensor-line drive:
  - Each line is driven only with 0 or Z; a line is never driven high.
  - Non-selected channels are always Z.
  - Each `dht_io` input passes through a 2-FF synchroniser.
- Start conditions:
  - A start occurs on a START write with BUSY=0, or on an auto trigger.
  - CH_SEL is latched at start. CH_SEL ≥ NUM_CH selects channel 0.
  - A START write while BUSY=1 is ignored.
- At start: BUSY=1, VALID, CKSUM_ERR and TIMEOUT_ERR clear, DONE is unchanged.
- Engine FSM (counters step on the 1 µs tick; µs counter reset on every state entry):
  - IDLE: line Z.
  - HOST_LOW: drive 0 for START_US.
  - HOST_REL: Z for REL_US.
  - RESP_LOW: wait for sync input = 1.
  - RESP_HIGH: wait for 0.
  - BIT_LOW: wait for 1.
  - BIT_HIGH: count µs until 0, then shift in bit (count > BIT1_TH_US) MSB-first; after 40 bits go to CHECK, else BIT_LOW.
  - CHECK: one cycle, then IDLE.
- Timeout: in RESP_LOW, RESP_HIGH, BIT_LOW or BIT_HIGH, a µs count reaching TIMEOUT_US sets TIMEOUT_ERR and DONE and returns to IDLE. DATA and SUM are unchanged.
- CHECK stage:
  - computed = (b4+b3+b2+b1) mod 256; SUM is always updated.
  - On a match: DATA updated, VALID=1.
  - Else: CKSUM_ERR=1, DATA unchanged.
  - DONE=1 in both cases.
- Auto mode: with AUTO=1, an ms counter runs while BUSY=0 and restarts at each completion. Reaching PERIOD triggers a start. Clearing AUTO resets the counter.
- irq = IRQ_EN & DONE. If a DONE set and a W1C clear land in the same cycle, the set wins.

## Timing
- PREADY = PSEL & PENABLE (zero wait states). PRDATA is combinational from the registers during the access phase and 0 otherwise.
- Writes take effect at the PCLK edge ending the access phase. The engine leaves IDLE one cycle after a START write.
- BUSY drops and DONE rises in the same cycle the FSM returns to IDLE.
- Sensor edges are observed 2–3 PCLK plus ≤1 µs late. Bit decisions tolerate ±1 µs.
- Reset values:
  - All registers 0.
  - PRDATA=0, irq=0, all `dht_io` Z, FSM in IDLE.
  - PRESETn asserted mid-frame releases the line immediately (asynchronously) and discards the partial frame.

## Test plan
- Frame 0x35,0x00,0x18,0x05,0x52 on ch0 after START → STATUS=0x12 (DONE, VALID), DATA=0x35001805, SUM=0x5252.
- Same frame with checksum byte 0x53 → STATUS=0x14 (DONE, CKSUM_ERR), DATA keeps its previous value, SUM=0x5253.
- Sensor silent → TIMEOUT_ERR=1 and DONE=1 at START_US+REL_US+TIMEOUT_US µs (±1); line Z. With IRQ_EN=1, irq=1; writing STATUS 0x10 clears irq.
- Sensor model on ch2 with NUM_CH=4 and CH_SEL=2 → only dht_io[2] pulled low, others Z. A START written mid-frame is ignored and exactly one DONE results.
- AUTO=1, PERIOD=2 → successive starts 2 ms (±1 µs) after each completion; clearing AUTO stops further starts.
- PRESETn pulsed during BIT_HIGH → line Z immediately, all registers 0. A following START completes normally.
